// File: rtl/sprite_line_fetcher.sv
// -----------------------------------------------------------------------------
// sprite_line_fetcher
//
// Reader side of one sprite ROM (asynchronous read, address in / colour out).
// During horizontal blanking it copies the sprite row belonging to the next
// video line into a private line buffer. During active video it replays the
// buffered row whenever the beam lies inside the sprite's horizontal span.
// Pixels equal to the transparent key colour are reported as "no pixel".
// One instance is used per sprite, between the VGA timing generator and the
// pixel mixer.
//
// Optional build macro:
//   SPRITE_FETCH_MIRROR_EN - adds input mirror_x (sampled at line_start).
//                            When latched high the row is stored flipped
//                            left-to-right. Fetch timing is unchanged.
//
// Ports:
//   clk          in   1           pixel / system clock
//   rst          in   1           asynchronous active-high reset
//   hcount       in   CNT_BITS    current horizontal pixel position
//   vcount       in   CNT_BITS    current line number
//   line_start   in   1           one-cycle pulse at start of hblank
//   sprite_en    in   1           sprite visible
//   sprite_x     in   CNT_BITS    sprite left edge
//   sprite_y     in   CNT_BITS    sprite top edge
//   mirror_x     in   1           horizontal flip (SPRITE_FETCH_MIRROR_EN only)
//   rom_addr     out  ADDRESS     sprite ROM address (registered)
//   rom_data     in   COLOR_BITS  ROM data for rom_addr, same cycle
//   busy         out  1           row fetch in progress
//   pixel_valid  out  1           pixel_color is an opaque sprite pixel for
//                                 the previous cycle's hcount
//   pixel_color  out  COLOR_BITS  sprite colour (0 outside the sprite)
// -----------------------------------------------------------------------------
module sprite_line_fetcher #(
  parameter int                    ADDRESS     = 10,
  parameter int                    COLOR_BITS  = 24,
  parameter int                    SPRITE_W    = 32,
  parameter int                    SPRITE_H    = 32,
  parameter int                    CNT_BITS    = 10,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT = 24'hFF00FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_BITS-1:0]   hcount,
  input  logic [CNT_BITS-1:0]   vcount,
  input  logic                  line_start,
  input  logic                  sprite_en,
  input  logic [CNT_BITS-1:0]   sprite_x,
  input  logic [CNT_BITS-1:0]   sprite_y,
`ifdef SPRITE_FETCH_MIRROR_EN
  input  logic                  mirror_x,
`endif
  output logic [ADDRESS-1:0]    rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic                  busy,
  output logic                  pixel_valid,
  output logic [COLOR_BITS-1:0] pixel_color
);

  localparam int COL_W = $clog2(SPRITE_W);

  localparam logic [COL_W-1:0]    COL_ZERO = COL_W'(0);
  localparam logic [COL_W-1:0]    COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(SPRITE_W - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] ROW_LIM  = CNT_BITS'(SPRITE_H);
  localparam logic [CNT_BITS-1:0] COL_LIM  = CNT_BITS'(SPRITE_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // ROM address of (row, col). SPRITE_W is a power of two, so the product
  // row*SPRITE_W + col is simply the concatenation {row, col}.
  function automatic logic [ADDRESS-1:0] row_base(
    input logic [CNT_BITS-1:0] r,
    input logic [COL_W-1:0]    c
  );
    return ADDRESS'({r, c});
  endfunction

  // Control registers and their next-state values
  state_e                  state_q,      state_d;
  logic                    line_valid_q, line_valid_d;
  logic [CNT_BITS-1:0]     row_q,        row_d;
  logic [COL_W-1:0]        col_q,        col_d;
  logic [CNT_BITS-1:0]     x_lat_q,      x_lat_d;
  logic                    mirror_q,     mirror_d;
  logic [ADDRESS-1:0]      addr_q,       addr_d;
  logic                    busy_q,       busy_d;
  logic                    pix_valid_q,  pix_valid_d;
  logic [COLOR_BITS-1:0]   pix_color_q,  pix_color_d;

  // Line buffer (no reset needed: line_valid gates every read)
  logic [COLOR_BITS-1:0]   line_buf_q [SPRITE_W];
  logic                    buf_we_s;
  logic [COL_W-1:0]        buf_widx_s;

  // line_start decode helpers
  logic                    mirror_in_s;
  logic [CNT_BITS-1:0]     tgt_s;
  logic [CNT_BITS:0]       row_diff_s;
  logic                    row_hit_s;

  // Display path helpers
  logic [CNT_BITS:0]       dx_s;
  logic                    hit_s;
  logic [COLOR_BITS-1:0]   rd_pix_s;

`ifdef SPRITE_FETCH_MIRROR_EN
  assign mirror_in_s = mirror_x;
`else
  assign mirror_in_s = 1'b0;
`endif

  // Target line is the one after the current one; the difference to the
  // sprite top is taken one bit wider so a sprite below the line shows up
  // as a negative row instead of wrapping into a large positive one.
  assign tgt_s      = vcount + CNT_ONE;
  assign row_diff_s = {1'b0, tgt_s} - {1'b0, sprite_y};
  assign row_hit_s  = sprite_en && !row_diff_s[CNT_BITS] &&
                      (row_diff_s[CNT_BITS-1:0] < ROW_LIM);

  // Same widening for the horizontal offset: beam positions left of the
  // latched edge are negative, so a sprite near the right border never wraps
  // around to the left side of the screen.
  assign dx_s     = {1'b0, hcount} - {1'b0, x_lat_q};
  assign hit_s    = line_valid_q && !dx_s[CNT_BITS] &&
                    (dx_s[CNT_BITS-1:0] < COL_LIM);
  assign rd_pix_s = line_buf_q[dx_s[COL_W-1:0]];

  // Mirrored rows land at SPRITE_W-1-col, which is ~col for a power-of-two width
  assign buf_widx_s = mirror_q ? ~col_q : col_q;

  // Fetch FSM: next state, fetch counters and ROM address
  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    row_d        = row_q;
    col_d        = col_q;
    x_lat_d      = x_lat_q;
    mirror_d     = mirror_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    buf_we_s     = 1'b0;

    if (line_start) begin
      // line_start wins in every state, aborting any fetch in flight
      x_lat_d      = sprite_x;
      mirror_d     = mirror_in_s;
      line_valid_d = 1'b0;
      if (row_hit_s) begin
        state_d = ST_FETCH;
        row_d   = row_diff_s[CNT_BITS-1:0];
        col_d   = COL_ZERO;
        addr_d  = row_base(row_diff_s[CNT_BITS-1:0], COL_ZERO);
        busy_d  = 1'b1;
      end else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          // rom_data belongs to addr_q, i.e. to (row_q, col_q)
          buf_we_s = 1'b1;
          if (col_q == COL_LAST) begin
            state_d      = ST_READY;
            line_valid_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            col_d  = col_q + COL_ONE;
            addr_d = row_base(row_q, col_q + COL_ONE);
          end
        end
        ST_IDLE: begin
          busy_d = 1'b0;
        end
        ST_READY: begin
          busy_d = 1'b0;
        end
        default: begin
          state_d      = ST_IDLE;
          line_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
      endcase
    end
  end

  // Display path: registered pixel lookup, active in every state
  always_comb begin
    pix_valid_d = 1'b0;
    pix_color_d = '0;
    if (hit_s) begin
      pix_valid_d = (rd_pix_s != TRANSPARENT);
      pix_color_d = rd_pix_s;
    end else begin
      pix_valid_d = 1'b0;
      pix_color_d = '0;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_valid_q <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      x_lat_q      <= '0;
      mirror_q     <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_color_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      x_lat_q      <= x_lat_d;
      mirror_q     <= mirror_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      pix_valid_q  <= pix_valid_d;
      pix_color_q  <= pix_color_d;
    end
  end

  // Line buffer write port, one pixel per fetch cycle
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      line_buf_q[buf_widx_s] <= rom_data;
    end
  end

  assign rom_addr    = addr_q;
  assign busy        = busy_q;
  assign pixel_valid = pix_valid_q;
  assign pixel_color = pix_color_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sprite_line_fetcher. A behavioural ROM feeds the
// DUT; a line-level reference model (which ROM row is visible on the next
// line, where its left edge sits, whether it is mirrored) predicts busy,
// rom_addr, pixel_valid and pixel_color.
// -----------------------------------------------------------------------------
module tb_sprite_line_fetcher;

  localparam int AW = 10;
  localparam int CB = 24;
  localparam int SW = 32;
  localparam int SH = 32;
  localparam int CW = 10;
  localparam int HMAX = 1 << CW;
  localparam logic [CB-1:0] TRANS = 24'hFF00FF;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] hcount, vcount, sprite_x, sprite_y;
  logic          line_start, sprite_en;
`ifdef SPRITE_FETCH_MIRROR_EN
  logic          mirror_x;
`endif
  logic [AW-1:0] rom_addr;
  logic [CB-1:0] rom_data;
  logic          busy, pixel_valid;
  logic [CB-1:0] pixel_color;

  logic [CB-1:0] rom_mem [HMAX];
  assign rom_data = rom_mem[rom_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit            m_pending;
  bit            m_ready;
  bit            m_mir;
  int            m_row;
  int            m_x;
  logic [CB-1:0] m_line [SW];

  sprite_line_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .line_start (line_start),
    .sprite_en  (sprite_en),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
`ifdef SPRITE_FETCH_MIRROR_EN
    .mirror_x   (mirror_x),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .pixel_valid(pixel_valid),
    .pixel_color(pixel_color)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a line_start pulse and record what the next line should contain
  task automatic start_line(input int v, input int y, input int x, input bit en, input bit mir);
    int tgt;
    vcount     = CW'(v);
    sprite_y   = CW'(y);
    sprite_x   = CW'(x);
    sprite_en  = en;
    m_mir      = mir;
`ifdef SPRITE_FETCH_MIRROR_EN
    mirror_x   = mir;
`else
    m_mir      = 1'b0;
`endif
    tgt        = (v + 1) % HMAX;
    m_row      = tgt - y;
    m_pending  = en && (m_row >= 0) && (m_row < SH);
    m_ready    = 1'b0;
    m_x        = x;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Follow a fetch (or its absence) until the row would be available
  task automatic fetch_check();
    if (m_pending) begin
      for (int i = 0; i < SW; i++) begin
        chk("fetch_addr", 32'(rom_addr), 32'(m_row * SW + i));
        chk("fetch_busy", 32'(busy), 32'd1);
        if (i > 0) chk("fetch_pv", 32'(pixel_valid), 32'd0);
        tick();
      end
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_addr", 32'(rom_addr), 32'(m_row * SW + SW - 1));
      for (int i = 0; i < SW; i++)
        m_line[i] = rom_mem[m_row * SW + (m_mir ? (SW - 1 - i) : i)];
      m_ready = 1'b1;
    end else begin
      for (int i = 0; i <= SW; i++) begin
        chk("idle_busy", 32'(busy), 32'd0);
        if (i > 0) chk("idle_pv", 32'(pixel_valid), 32'd0);
        tick();
      end
    end
  endtask

  // Sweep the beam over n positions starting at h0 (wrapping at the line end)
  task automatic sweep(input int h0, input int n);
    int h, dx;
    bit hit;
    logic [CB-1:0] col;
    for (int k = 0; k < n; k++) begin
      h      = (h0 + k) % HMAX;
      hcount = CW'(h);
      tick();
      dx  = h - m_x;
      hit = m_ready && (dx >= 0) && (dx < SW);
      col = hit ? m_line[dx] : '0;
      chk("pix_valid", 32'(pixel_valid), 32'(hit && (col != TRANS)));
      chk("pix_color", 32'(pixel_color), 32'(col));
    end
  endtask

  initial begin
    int v, y, x, r;
    bit en, mir;

    // ROM image: random opaque colours plus a few keyed pixels
    for (int i = 0; i < HMAX; i++) begin
      rom_mem[i] = CB'($urandom);
      if (rom_mem[i] == TRANS) rom_mem[i] = 24'h000001;
    end
    rom_mem[5 * SW + 3] = TRANS;
    for (int i = 0; i < 12; i++)
      rom_mem[$urandom_range(10 * SW, HMAX - 1)] = TRANS;

    rst = 1'b1; hcount = '0; vcount = '0; line_start = 1'b0; sprite_en = 1'b0;
    sprite_x = '0; sprite_y = '0;
`ifdef SPRITE_FETCH_MIRROR_EN
    mirror_x = 1'b0;
`endif
    m_ready = 1'b0; m_pending = 1'b0; m_mir = 1'b0; m_row = 0; m_x = 0;
    tick(); tick();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_pv",    32'(pixel_valid), 32'd0);
    chk("rst_addr",  32'(rom_addr), 32'd0);
    chk("rst_color", 32'(pixel_color), 32'd0);
    rst = 1'b0;
    tick();

    // Top row of the sprite, then a beam sweep across its span
    start_line(99, 100, 200, 1'b1, 1'b0);
    fetch_check();
    sweep(190, 51);

    // Reset in the middle of a fetch clears outputs immediately
    start_line(99, 100, 200, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pv",   32'(pixel_valid), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    tick();
    rst = 1'b0;
    m_ready = 1'b0;
    sweep(195, 40);

    // Row 5 contains a keyed pixel at column 3
    start_line(104, 100, 200, 1'b1, 1'b0);
    fetch_check();
    sweep(195, 45);

    // Vertical boundaries: one line above, one line below, last row, disabled
    start_line(98, 100, 200, 1'b1, 1'b0);
    fetch_check();
    sweep(195, 40);
    start_line(131, 100, 200, 1'b1, 1'b0);
    fetch_check();
    sweep(195, 40);
    start_line(104, 100, 200, 1'b0, 1'b0);
    fetch_check();
    start_line(130, 100, 200, 1'b1, 1'b0);
    fetch_check();
    sweep(195, 40);

    // Restart mid-fetch with a new row; beam parked inside the new span
    hcount = CW'(301);
    start_line(110, 100, 300, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort_pv", 32'(pixel_valid), 32'd0);
    end
    start_line(115, 100, 300, 1'b1, 1'b0);
    fetch_check();
    // Inputs changing mid-line must not disturb the latched line
    sprite_x = '0; sprite_y = '0; sprite_en = 1'b0;
    sweep(295, 40);

    // Right edge with vcount at its maximum (target line 0), mirrored if built in
    start_line(HMAX - 1, 0, 1010, 1'b1, 1'b1);
    fetch_check();
    sweep(1000, 44);

    // Randomized lines
    for (int it = 0; it < 8; it++) begin
      v   = $urandom_range(0, HMAX - 1);
      r   = $urandom_range(0, 40) - 4;
      y   = (((v + 1 - r) % HMAX) + HMAX) % HMAX;
      x   = $urandom_range(0, HMAX - 1);
      en  = ($urandom_range(0, 7) != 0);
      mir = 1'($urandom_range(0, 1));
      start_line(v, y, x, en, mir);
      fetch_check();
      sweep((x + HMAX - 4) % HMAX, 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
